// File: rtl/gpreg_pkg.sv
// Shared types and constants for the gpreg context save/restore engine.
// The RS_VFY state exists only when GPCTX_VERIFY_EN is defined.
package gpreg_pkg;

  localparam int GP_NREGS = 32;
  localparam int GP_AW    = 5;
  localparam int GP_DW    = 8;

  localparam logic GPCTX_SAVE    = 1'b0;
  localparam logic GPCTX_RESTORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SV_RD   = 3'd1,
    ST_SV_WAIT = 3'd2,
    ST_RS_WAIT = 3'd3,
    ST_RS_WR   = 3'd4,
    ST_DONE    = 3'd6
`ifdef GPCTX_VERIFY_EN
    ,
    ST_RS_VFY  = 3'd5
`endif
  } gpctx_state_t;

endpackage

// File: rtl/gpreg_ctx_engine.sv
// Context save/restore initiator driving the address/write side of the gpreg file.
// Optional read-back verify of each restored register: define GPCTX_VERIFY_EN.
module gpreg_ctx_engine
  import gpreg_pkg::*;
#(
  parameter int NREGS     = GP_NREGS,
  parameter int AW        = GP_AW,
  parameter int DW        = GP_DW,
  parameter int FIRST_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rf_rA,
  output logic [AW-1:0] rf_rB,
  output logic [DW-1:0] rf_din,
  output logic          rf_we,
  input  logic [DW-1:0] rf_outA,
  input  logic [DW-1:0] rf_outB,
  output logic [DW-1:0] sv_data,
  output logic          sv_valid,
  input  logic          sv_ready,
  input  logic [DW-1:0] rs_data,
  input  logic          rs_valid,
  output logic          rs_ready,
  output logic [2:0]    dbg_state
);

  localparam logic [AW-1:0] LP_FIRST = AW'(FIRST_REG);
  localparam logic [AW-1:0] LP_LAST  = AW'(NREGS - 1);

  // Handshake rule on both streams: a beat transfers on a rising edge where
  // valid && ready; the producer holds data and valid stable until then.

  gpctx_state_t  r_state;
  gpctx_state_t  w_state_n;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_inc;
  logic          w_last;
  logic          w_sv_hs;
  logic          w_rs_hs;

  assign w_idx_inc = r_idx + AW'(1);
  assign w_last    = (r_idx == LP_LAST);
  assign w_sv_hs   = (r_state == ST_SV_WAIT) && sv_valid && sv_ready;
  assign w_rs_hs   = (r_state == ST_RS_WAIT) && rs_valid && rs_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_n = (mode == GPCTX_RESTORE) ? ST_RS_WAIT : ST_SV_RD;
      end
      ST_SV_RD:   w_state_n = ST_SV_WAIT;
      ST_SV_WAIT: begin
        if (w_sv_hs) w_state_n = w_last ? ST_DONE : ST_SV_RD;
      end
      ST_RS_WAIT: begin
        if (w_rs_hs) w_state_n = ST_RS_WR;
      end
`ifdef GPCTX_VERIFY_EN
      ST_RS_WR:   w_state_n = ST_RS_VFY;
      ST_RS_VFY:  w_state_n = w_last ? ST_DONE : ST_RS_WAIT;
`else
      ST_RS_WR:   w_state_n = w_last ? ST_DONE : ST_RS_WAIT;
`endif
      ST_DONE:    w_state_n = ST_IDLE;
      default:    w_state_n = ST_IDLE;
    endcase
  end

`ifdef GPCTX_VERIFY_EN
  logic r_err;
  assign err = r_err;
`else
  logic w_unused_outb;
  assign err           = 1'b0;
  assign w_unused_outb = ^rf_outB;
`endif

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= LP_FIRST;
      busy     <= 1'b0;
      done     <= 1'b0;
      rs_ready <= 1'b0;
      rf_rA    <= '0;
      rf_rB    <= '0;
      rf_din   <= '0;
      rf_we    <= 1'b0;
      sv_data  <= '0;
      sv_valid <= 1'b0;
`ifdef GPCTX_VERIFY_EN
      r_err    <= 1'b0;
`endif
    end else begin
      busy     <= (w_state_n != ST_IDLE);
      done     <= (w_state_n == ST_DONE);
      rs_ready <= (w_state_n == ST_RS_WAIT);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx <= LP_FIRST;
            if (mode == GPCTX_SAVE) rf_rA <= LP_FIRST;
`ifdef GPCTX_VERIFY_EN
            r_err <= 1'b0;
`endif
          end
        end
        ST_SV_RD: begin
          sv_data  <= rf_outA;
          sv_valid <= 1'b1;
        end
        ST_SV_WAIT: begin
          if (w_sv_hs) begin
            sv_valid <= 1'b0;
            if (!w_last) begin
              r_idx <= w_idx_inc;
              rf_rA <= w_idx_inc;
            end
          end
        end
        ST_RS_WAIT: begin
          if (w_rs_hs) begin
            rf_din <= rs_data;
            rf_rA  <= r_idx;
            rf_rB  <= r_idx;
            rf_we  <= 1'b1;
          end
        end
        ST_RS_WR: begin
          rf_we <= 1'b0;
`ifndef GPCTX_VERIFY_EN
          if (!w_last) r_idx <= w_idx_inc;
`endif
        end
`ifdef GPCTX_VERIFY_EN
        // The byte written at the end of RS_WR is now on rf_outB.
        ST_RS_VFY: begin
          if (rf_outB != rf_din) r_err <= 1'b1;
          if (!w_last) r_idx <= w_idx_inc;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpreg_ctx_engine.sv
// Directed bench for gpreg_ctx_engine with a behavioural 32 x 8 register file.
// Define GPCTX_VERIFY_EN for both bench and RTL to exercise the verify path.
module tb_gpreg_ctx_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic       busy, done, err;
  logic [4:0] rf_rA, rf_rB;
  logic [7:0] rf_din;
  logic       rf_we;
  logic [7:0] rf_outA, rf_outB;
  logic [7:0] sv_data;
  logic       sv_valid, sv_ready;
  logic [7:0] rs_data;
  logic       rs_valid, rs_ready;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] gpr      [32];
  logic [7:0] load_img [32];
  logic       load_en  = 1'b0;
  logic       force_b0 = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Register file model: writes through port A address, reads combinational.
  always @(posedge clk) begin
    if (load_en) gpr <= load_img;
    else if (rf_we) gpr[rf_rA] <= rf_din;
  end
  assign rf_outA = gpr[rf_rA];
  assign rf_outB = (force_b0 && rf_rB == 5'd5) ? 8'h00 : gpr[rf_rB];

  gpreg_ctx_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .rf_rA(rf_rA), .rf_rB(rf_rB), .rf_din(rf_din), .rf_we(rf_we),
    .rf_outA(rf_outA), .rf_outB(rf_outB),
    .sv_data(sv_data), .sv_valid(sv_valid), .sv_ready(sv_ready),
    .rs_data(rs_data), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .dbg_state(dbg_state)
  );

  task automatic preload(input int kind);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0: load_img[i] = 8'(2 * i + 2);
        1: load_img[i] = 8'h5A ^ 8'(i);
        2: load_img[i] = 8'hEE;
        default: load_img[i] = 8'h00;
      endcase
    end
    @(negedge clk); load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; mode = 1'b0;
    sv_ready = 1'b0; rs_valid = 1'b0; rs_data = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (err !== 1'b0)      begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (rf_we !== 1'b0)    begin bad++; $display("FAIL rst_we got=%b want=0", rf_we); end
    total++; if (rf_rA !== 5'd0)    begin bad++; $display("FAIL rst_rA got=%h want=0", rf_rA); end
    total++; if (rf_rB !== 5'd0)    begin bad++; $display("FAIL rst_rB got=%h want=0", rf_rB); end
    total++; if (rf_din !== 8'h00)  begin bad++; $display("FAIL rst_din got=%h want=0", rf_din); end
    total++; if (sv_valid !== 1'b0) begin bad++; $display("FAIL rst_svv got=%b want=0", sv_valid); end
    total++; if (sv_data !== 8'h00) begin bad++; $display("FAIL rst_svd got=%h want=0", sv_data); end
    total++; if (rs_ready !== 1'b0) begin bad++; $display("FAIL rst_rsr got=%b want=0", rs_ready); end
    start = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_ignored busy got=%b want=0", busy); end
  endtask

  task automatic test_save(input int kind, input bit stall);
    int cyc, done_cyc, done_cnt, we_cnt;
    bit prev_valid, prev_hs, hs;
    logic [7:0] prev_data;
    preload(kind);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(load_img[i]);
    cyc = 0; done_cyc = 0; done_cnt = 0; we_cnt = 0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_data = 8'h00;
    sv_ready = stall ? 1'b0 : 1'b1;
    start = 1'b1; mode = 1'b0;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rf_we) we_cnt++;
      if (prev_valid && !prev_hs) begin
        total++;
        if (sv_valid !== 1'b1 || sv_data !== prev_data) begin
          bad++; $display("FAIL sv_hold cyc=%0d got=%b/%h want=1/%h", cyc, sv_valid, sv_data, prev_data);
        end
      end
      sv_ready = stall ? (cyc % 3 == 0) : 1'b1;
      hs = sv_valid && sv_ready;
      if (hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL sv_extra_beat got=%h want=none", sv_data);
        end else if (sv_data !== exp_q[0]) begin
          bad++; $display("FAIL sv_beat got=%h want=%h", sv_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      prev_valid = sv_valid; prev_hs = hs; prev_data = sv_data;
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL sv_done_seen got=%0d want=1", done_cnt); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sv_beats_left got=%0d want=0", exp_q.size()); end
    total++; if (we_cnt != 0) begin bad++; $display("FAIL sv_we_pulses got=%0d want=0", we_cnt); end
    // Cycle count includes the edge that samples start as cycle 1.
    if (!stall) begin
      total++; if (done_cyc != 65) begin bad++; $display("FAIL sv_done_cycle got=%0d want=65", done_cyc); end
    end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL sv_idle_after got=%b%b want=00", done, busy);
    end
    sv_ready = 1'b0;
  endtask

  task automatic test_restore(input logic [7:0] base, input bit abort);
    int cyc, ptr, we_cnt, done_cnt, sv_seen;
    bit pend;
    preload(abort ? 2 : 3);
    cyc = 0; ptr = 0; we_cnt = 0; done_cnt = 0; sv_seen = 0; pend = 1'b0;
    rs_valid = 1'b1; rs_data = base;
    start = 1'b1; mode = 1'b1;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (pend) ptr++;
      if (done) done_cnt++;
      if (sv_valid) sv_seen++;
      if (rf_we) begin
        we_cnt++;
        if (abort && we_cnt == 11) begin
          total++; if (rf_rA !== 5'd10) begin bad++; $display("FAIL ab_addr got=%h want=0a", rf_rA); end
          reset = 1'b0;
          #1;
          total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ab_we_async got=%b want=0", rf_we); end
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy got=%b want=0", busy); end
          break;
        end
      end
      // A second command in the middle of the walk must be ignored.
      if (abort && cyc == 4) begin start = 1'b1; mode = 1'b0; end
      rs_valid = (ptr < 32);
      rs_data  = base + 8'(ptr);
      pend = rs_valid && rs_ready;
    end
    rs_valid = 1'b0;
    if (abort) begin
      repeat (3) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      reset = 1'b1;
      repeat (2) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL ab_done got=%0d want=0", done_cnt); end
      total++; if (sv_seen != 0) begin bad++; $display("FAIL ab_sv_valid got=%0d want=0", sv_seen); end
      for (int i = 0; i < 32; i++) begin
        total++;
        if (gpr[i] !== ((i < 10) ? base + 8'(i) : 8'hEE)) begin
          bad++; $display("FAIL ab_reg%0d got=%h want=%h", i, gpr[i], (i < 10) ? base + 8'(i) : 8'hEE);
        end
      end
    end else begin
      @(negedge clk);
      if (done) done_cnt++;
      total++; if (done_cnt != 1) begin bad++; $display("FAIL rs_done got=%0d want=1", done_cnt); end
      total++; if (we_cnt != 32) begin bad++; $display("FAIL rs_we_pulses got=%0d want=32", we_cnt); end
      total++; if (ptr != 32) begin bad++; $display("FAIL rs_beats got=%0d want=32", ptr); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rs_err got=%b want=0", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs_busy_after got=%b want=0", busy); end
      for (int i = 0; i < 32; i++) begin
        total++;
        if (gpr[i] !== base + 8'(i)) begin
          bad++; $display("FAIL rs_reg%0d got=%h want=%h", i, gpr[i], base + 8'(i));
        end
      end
    end
  endtask

`ifdef GPCTX_VERIFY_EN
  task automatic test_verify();
    int cyc, ptr;
    bit pend, got_done;
    preload(3);
    force_b0 = 1'b1;
    cyc = 0; ptr = 0; pend = 1'b0; got_done = 1'b0;
    rs_valid = 1'b1; rs_data = 8'h30;
    start = 1'b1; mode = 1'b1;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (pend) ptr++;
      if (done) begin
        got_done = 1'b1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL vf_err_at_done got=%b want=1", err); end
      end
      if (ptr == 4) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL vf_err_early got=%b want=0", err); end
      end
      rs_valid = (ptr < 32);
      rs_data  = 8'h30 + 8'(ptr);
      pend = rs_valid && rs_ready;
    end
    rs_valid = 1'b0; force_b0 = 1'b0;
    total++; if (!got_done) begin bad++; $display("FAIL vf_done got=0 want=1"); end
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL vf_err_sticky got=%b want=1", err); end
    sv_ready = 1'b1; start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL vf_err_clear got=%b want=0", err); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; sv_ready = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_save(0, 1'b0);
    test_save(1, 1'b1);
    test_restore(8'hA0, 1'b0);
    test_restore(8'h10, 1'b1);
`ifdef GPCTX_VERIFY_EN
    test_verify();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
